// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 codes and the memory-stage FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and memory (slave).
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/memory_stage_load_extend.sv
// Load lane selection by address low bits and sign/zero extension by funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/half lane, then extend according to the load type.
    always_comb begin
        byte_s = 8'h00;
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext    = rdata;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        case (funct3)
            F3_LB:   ext = {{24{byte_s[7]}}, byte_s};
            F3_LH:   ext = {{16{half_s[15]}}, half_s};
            F3_LBU:  ext = {24'h000000, byte_s};
            F3_LHU:  ext = {16'h0000, half_s};
            F3_LW:   ext = rdata;
            default: ext = rdata;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// RISC-V memory stage: data-memory access FSM, store lane steering and M->W pipeline register.
// Optional MISALIGN_TRAP_EN suppresses misaligned accesses and adds the W_misalign pulse.
module memory_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          M_mem_read,
    input  logic          M_mem_write,
    input  logic [2:0]    M_funct3,
    input  logic [31:0]   M_alu_result,
    input  logic [31:0]   M_write_data,
    input  logic [31:0]   M_pc_auipc_target,
    input  logic [31:0]   M_pc_plus_4,
    input  logic [1:0]    M_rd_src_sel,
    input  logic          M_reg_write,
    input  logic [4:0]    M_rd_addr,
    memory_stage_if.master dmem,
    output logic          M_stall,
    output logic [31:0]   W_alu_result,
    output logic [31:0]   W_load_ext,
    output logic [31:0]   W_pc_auipc_target,
    output logic [31:0]   W_pc_plus_4,
    output logic [1:0]    W_rd_src_sel,
    output logic          W_reg_write,
`ifdef MISALIGN_TRAP_EN
    output logic          W_misalign,
`endif
    output logic [4:0]    W_rd_addr
);
    mem_state_t  state_r, state_next_s;
    logic        access_s, misalign_s, issue_s, req_s;
    logic [31:0] load_ext_s;

    assign access_s = M_mem_read | M_mem_write;
`ifdef MISALIGN_TRAP_EN
    assign misalign_s = access_s &
                        (((M_funct3[1:0] == 2'b01) & M_alu_result[0]) |
                         ((M_funct3[1:0] == 2'b10) & (M_alu_result[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif
    assign issue_s = access_s & ~misalign_s;

    // Next-state and request generation; a same-cycle response in IDLE never enters WAIT.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = issue_s;
                if (issue_s && !dmem.dmem_rvalid) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem.dmem_rvalid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                req_s        = 1'b0;
            end
        endcase
    end

    // Access FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Gating with rst_n keeps the bus quiet for the whole reset interval.
    assign dmem.dmem_req  = req_s & rst_n;
    assign dmem.dmem_we   = M_mem_write;
    assign dmem.dmem_addr = {M_alu_result[31:2], 2'b00};
    assign M_stall        = dmem.dmem_req & ~dmem.dmem_rvalid;

    // Store byte enables and lane-replicated write data.
    always_comb begin
        dmem.dmem_wstrb = 4'b0000;
        dmem.dmem_wdata = M_write_data;
        if (M_mem_write) begin
            case (M_funct3)
                F3_SB: begin
                    dmem.dmem_wstrb = 4'b0001 << M_alu_result[1:0];
                    dmem.dmem_wdata = {4{M_write_data[7:0]}};
                end
                F3_SH: begin
                    dmem.dmem_wstrb = 4'b0011 << {M_alu_result[1], 1'b0};
                    dmem.dmem_wdata = {2{M_write_data[15:0]}};
                end
                F3_SW: begin
                    dmem.dmem_wstrb = 4'b1111;
                    dmem.dmem_wdata = M_write_data;
                end
                default: begin
                    dmem.dmem_wstrb = 4'b0000;
                    dmem.dmem_wdata = M_write_data;
                end
            endcase
        end else begin
            dmem.dmem_wstrb = 4'b0000;
            dmem.dmem_wdata = M_write_data;
        end
    end

    load_extend u_load_extend (
        .funct3  (M_funct3),
        .addr_lo (M_alu_result[1:0]),
        .rdata   (dmem.dmem_rdata),
        .ext     (load_ext_s)
    );

    // M->W pipeline register: bubble while stalled, otherwise capture the M stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_alu_result      <= 32'h0000_0000;
            W_load_ext        <= 32'h0000_0000;
            W_pc_auipc_target <= 32'h0000_0000;
            W_pc_plus_4       <= 32'h0000_0000;
            W_rd_src_sel      <= 2'b00;
            W_reg_write       <= 1'b0;
            W_rd_addr         <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            W_misalign        <= 1'b0;
`endif
        end else if (M_stall) begin
            W_reg_write       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            W_misalign        <= 1'b0;
`endif
        end else begin
            W_alu_result      <= M_alu_result;
            W_load_ext        <= (M_mem_read && !misalign_s) ? load_ext_s : 32'h0000_0000;
            W_pc_auipc_target <= M_pc_auipc_target;
            W_pc_plus_4       <= M_pc_plus_4;
            W_rd_src_sel      <= M_rd_src_sel;
            W_reg_write       <= M_reg_write & ~misalign_s;
            W_rd_addr         <= M_rd_addr;
`ifdef MISALIGN_TRAP_EN
            W_misalign        <= misalign_s;
`endif
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (also covers MISALIGN_TRAP_EN when defined).
module tb_memory_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_mem_read, M_mem_write, M_reg_write, M_stall;
    logic [2:0]  M_funct3;
    logic [31:0] M_alu_result, M_write_data, M_pc_auipc_target, M_pc_plus_4;
    logic [1:0]  M_rd_src_sel, W_rd_src_sel;
    logic [4:0]  M_rd_addr, W_rd_addr;
    logic [31:0] W_alu_result, W_load_ext, W_pc_auipc_target, W_pc_plus_4;
    logic        W_reg_write;
`ifdef MISALIGN_TRAP_EN
    logic        W_misalign;
`endif
    int          vectors = 0;
    int          miscompares = 0;
    int          stall_cycles;

    memory_stage_if dmem ();

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst_n(rst_n),
        .M_mem_read(M_mem_read), .M_mem_write(M_mem_write), .M_funct3(M_funct3),
        .M_alu_result(M_alu_result), .M_write_data(M_write_data),
        .M_pc_auipc_target(M_pc_auipc_target), .M_pc_plus_4(M_pc_plus_4),
        .M_rd_src_sel(M_rd_src_sel), .M_reg_write(M_reg_write), .M_rd_addr(M_rd_addr),
        .dmem(dmem.master), .M_stall(M_stall),
        .W_alu_result(W_alu_result), .W_load_ext(W_load_ext),
        .W_pc_auipc_target(W_pc_auipc_target), .W_pc_plus_4(W_pc_plus_4),
        .W_rd_src_sel(W_rd_src_sel), .W_reg_write(W_reg_write),
`ifdef MISALIGN_TRAP_EN
        .W_misalign(W_misalign),
`endif
        .W_rd_addr(W_rd_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sel,
                         input logic rw, input logic [4:0] rdst);
        M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_alu_result = a;
        M_write_data = wd; M_rd_src_sel = sel; M_reg_write = rw; M_rd_addr = rdst;
        M_pc_auipc_target = a + 32'h0000_1000; M_pc_plus_4 = a + 32'h0000_0004;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
        drive(1'b1, 1'b0, F3_LW, 32'h0000_0040, 32'h0, 2'd1, 1'b1, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("rst_w_alu", W_alu_result, 32'd0);
        chk("rst_w_rw", {31'd0, W_reg_write}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 2'd0, 1'b1, 5'd5);
        rst_n = 1'b1;

        // ALU op
        step();
        chk("alu_stall", {31'd0, M_stall}, 32'd0);
        chk("alu_w_alu", W_alu_result, 32'h0000_1234);
        chk("alu_w_rw", {31'd0, W_reg_write}, 32'd1);
        chk("alu_w_rd", {27'd0, W_rd_addr}, 32'd5);
        chk("alu_w_ext", W_load_ext, 32'd0);
        chk("alu_w_pc4", W_pc_plus_4, 32'h0000_1238);

        // LB 0x103, response after 3 stall cycles
        drive(1'b1, 1'b0, F3_LB, 32'h0000_0103, 32'h0, 2'd1, 1'b1, 5'd7);
        #1;
        chk("lb_req", {31'd0, dmem.dmem_req}, 32'd1);
        chk("lb_addr", dmem.dmem_addr, 32'h0000_0100);
        chk("lb_wstrb", {28'd0, dmem.dmem_wstrb}, 32'd0);
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (M_stall) stall_cycles++;
            step();
            chk("lb_bubble", {31'd0, W_reg_write}, 32'd0);
        end
        chk("lb_hold_alu", W_alu_result, 32'h0000_1234);
        chk("lb_stall_cnt", stall_cycles, 32'd3);
        dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_stall_rel", {31'd0, M_stall}, 32'd0);
        step();
        chk("lb_ext", W_load_ext, 32'hFFFF_FF80);
        chk("lb_w_rw", {31'd0, W_reg_write}, 32'd1);
        chk("lb_w_rd", {27'd0, W_rd_addr}, 32'd7);
        chk("lb_w_sel", {30'd0, W_rd_src_sel}, 32'd1);

        // SH 0x102, zero-wait completion
        drive(1'b0, 1'b1, F3_SH, 32'h0000_0102, 32'h0000_ABCD, 2'd0, 1'b0, 5'd0);
        #1;
        chk("sh_addr", dmem.dmem_addr, 32'h0000_0100);
        chk("sh_wstrb", {28'd0, dmem.dmem_wstrb}, 32'h0000_000C);
        chk("sh_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, dmem.dmem_we}, 32'd1);
        step();
        chk("sh_w_ext", W_load_ext, 32'd0);

        // SB 0x101
        drive(1'b0, 1'b1, F3_SB, 32'h0000_0101, 32'h1234_565A, 2'd0, 1'b0, 5'd0);
        #1;
        chk("sb_wstrb", {28'd0, dmem.dmem_wstrb}, 32'h0000_0002);
        chk("sb_wdata", dmem.dmem_wdata, 32'h5A5A_5A5A);
        step();

        // LHU 0x202, zero-wait
        drive(1'b1, 1'b0, F3_LHU, 32'h0000_0202, 32'h0, 2'd1, 1'b1, 5'd9);
        dmem.dmem_rdata = 32'hBEEF_0000;
        #1;
        chk("lhu_stall", {31'd0, M_stall}, 32'd0);
        step();
        chk("lhu_ext", W_load_ext, 32'h0000_BEEF);

        // LH 0x200 sign-extend, LBU 0x201 zero-extend
        drive(1'b1, 1'b0, F3_LH, 32'h0000_0200, 32'h0, 2'd1, 1'b1, 5'd10);
        dmem.dmem_rdata = 32'h0000_8001;
        step();
        chk("lh_ext", W_load_ext, 32'hFFFF_8001);
        drive(1'b1, 1'b0, F3_LBU, 32'h0000_0201, 32'h0, 2'd1, 1'b1, 5'd11);
        dmem.dmem_rdata = 32'h0000_F000;
        step();
        chk("lbu_ext", W_load_ext, 32'h0000_00F0);

        // LW at 0x101 (misaligned)
        drive(1'b1, 1'b0, F3_LW, 32'h0000_0101, 32'h0, 2'd1, 1'b1, 5'd12);
        dmem.dmem_rdata = 32'hCAFE_F00D;
        #1;
`ifdef MISALIGN_TRAP_EN
        dmem.dmem_rvalid = 1'b0;
        #1;
        chk("mis_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, M_stall}, 32'd0);
        step();
        chk("mis_pulse", {31'd0, W_misalign}, 32'd1);
        chk("mis_w_rw", {31'd0, W_reg_write}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 2'd0, 1'b1, 5'd1);
        step();
        chk("mis_pulse_end", {31'd0, W_misalign}, 32'd0);
        dmem.dmem_rvalid = 1'b1;
`else
        chk("mis_req", {31'd0, dmem.dmem_req}, 32'd1);
        chk("mis_addr", dmem.dmem_addr, 32'h0000_0100);
        step();
        chk("mis_ext", W_load_ext, 32'hCAFE_F00D);
        chk("mis_w_rw", {31'd0, W_reg_write}, 32'd1);
`endif

        // rvalid while idle with no access is ignored
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0020, 32'h0, 2'd0, 1'b0, 5'd0);
        #1;
        chk("idle_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("idle_stall", {31'd0, M_stall}, 32'd0);
        step();
        dmem.dmem_rvalid = 1'b0;
        drive(1'b1, 1'b0, F3_LW, 32'h0000_0300, 32'h0, 2'd1, 1'b1, 5'd13);
        #1;
        chk("idle_then_stall", {31'd0, M_stall}, 32'd1);

        // Reset while in WAIT
        step();
        chk("wait_state", {31'd0, dut.state_r}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'd0, dmem.dmem_req}, 32'd0);
        chk("rstw_state", {31'd0, dut.state_r}, 32'd0);
        chk("rstw_alu", W_alu_result, 32'd0);
        chk("rstw_pc4", W_pc_plus_4, 32'd0);
        chk("rstw_rd", {27'd0, W_rd_addr}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'd0, dmem.dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
